// File: rtl/life_gen_engine.sv
// life_gen_engine: computes one Game of Life generation per start pulse.
// The current board is streamed row by row from the read port. Each
// next-generation row goes out on the write port as soon as its lower
// neighbour row arrives, so the writes run back to back.
// Build option: define LIFE_WRAP_EN to treat the board as a torus.
// Left undefined, cells beyond the edges are dead.

module life_gen_engine #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned HEIGHT = 16,
  parameter int unsigned AW     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_en,
  output logic [AW-1:0]             rd_addr,
  input  logic [WIDTH-1:0]          rd_data,
  output logic                      wr_en,
  output logic [AW-1:0]             wr_addr,
  output logic [WIDTH-1:0]          wr_data,
  output logic [AW+$clog2(WIDTH):0] alive_count
);

  localparam int unsigned CW       = AW + $clog2(WIDTH) + 1;
  localparam int unsigned CNTW     = $clog2(HEIGHT + 2);
  localparam logic [AW-1:0] LAST_ROW = AW'(HEIGHT - 1);
`ifdef LIFE_WRAP_EN
  localparam int unsigned NREAD      = HEIGHT + 1;
  localparam logic [AW-1:0] FIRST_ADDR = LAST_ROW;
`else
  localparam int unsigned NREAD      = HEIGHT;
  localparam logic [AW-1:0] FIRST_ADDR = '0;
`endif

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  state_t          state, state_d;
  logic            busy_d, done_d, rd_en_d, wr_en_d, gen_start;
  logic [AW-1:0]   rd_addr_d, wr_addr_d;
  logic [CNTW-1:0] rd_idx, rd_idx_d;
  logic [CNTW-1:0] rx_cnt;
  logic            rd_valid;
  logic [CW-1:0]   acc, pop, alive_d;

  logic [WIDTH-1:0] above, centre, below_row, next_row, wr_hold;
  logic [WIDTH+1:0] ext_a, ext_c, ext_b;
  logic [3:0]       n;
`ifdef LIFE_WRAP_EN
  logic [WIDTH-1:0] row0;
`endif

  // Control state and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      rd_idx      <= '0;
      alive_count <= '0;
    end else begin
      state       <= state_d;
      busy        <= busy_d;
      done        <= done_d;
      rd_en       <= rd_en_d;
      rd_addr     <= rd_addr_d;
      rd_idx      <= rd_idx_d;
      alive_count <= alive_d;
    end
  end

  // Next-state and next-output decode for the generation sequence.
  always_comb begin
    state_d   = state;
    busy_d    = busy;
    done_d    = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr;
    rd_idx_d  = rd_idx;
    alive_d   = alive_count;
    gen_start = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d   = READ;
          busy_d    = 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = FIRST_ADDR;
          rd_idx_d  = CNTW'(1);
          gen_start = 1'b1;
        end
      end
      READ: begin
        if (rd_idx < CNTW'(NREAD)) begin
          rd_en_d  = 1'b1;
`ifdef LIFE_WRAP_EN
          rd_addr_d = AW'(rd_idx - CNTW'(1));
`else
          rd_addr_d = AW'(rd_idx);
`endif
          rd_idx_d = rd_idx + CNTW'(1);
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (wr_en && (wr_addr == LAST_ROW)) begin
          state_d = FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          alive_d = acc + pop;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Write strobe follows each arriving row once the row above is in place.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
`ifdef LIFE_WRAP_EN
    if (rd_valid && (rx_cnt != '0)) begin
      wr_en_d   = 1'b1;
      wr_addr_d = AW'(rx_cnt - CNTW'(1));
    end
`else
    if (rd_valid) begin
      wr_en_d   = 1'b1;
      wr_addr_d = AW'(rx_cnt);
    end
`endif
  end

  // Row window, read tracking, write port registers and the live-cell sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rx_cnt   <= '0;
      above    <= '0;
      centre   <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_hold  <= '0;
      acc      <= '0;
`ifdef LIFE_WRAP_EN
      row0     <= '0;
`endif
    end else begin
      rd_valid <= rd_en;
      wr_en    <= wr_en_d;
      wr_addr  <= wr_addr_d;
      if (wr_en) begin
        wr_hold <= next_row;
      end
      if (gen_start) begin
        rx_cnt <= '0;
        above  <= '0;
        centre <= '0;
        acc    <= '0;
`ifdef LIFE_WRAP_EN
        row0   <= '0;
`endif
      end else begin
        if (rd_valid) begin
          rx_cnt <= rx_cnt + CNTW'(1);
          above  <= centre;
          centre <= rd_data;
`ifdef LIFE_WRAP_EN
          if (rx_cnt == CNTW'(1)) begin
            row0 <= rd_data;
          end
`endif
        end
        if (wr_en) begin
          acc <= acc + pop;
        end
      end
    end
  end

  // The lower neighbour row is the arriving row, or the boundary row once reads end.
  always_comb begin
`ifdef LIFE_WRAP_EN
    below_row = rd_valid ? rd_data : row0;
`else
    below_row = rd_valid ? rd_data : '0;
`endif
  end

`ifdef LIFE_WRAP_EN
  assign ext_a = {above[0], above, above[WIDTH-1]};
  assign ext_c = {centre[0], centre, centre[WIDTH-1]};
  assign ext_b = {below_row[0], below_row, below_row[WIDTH-1]};
`else
  assign ext_a = {1'b0, above, 1'b0};
  assign ext_c = {1'b0, centre, 1'b0};
  assign ext_b = {1'b0, below_row, 1'b0};
`endif

  // Life rule for every cell of the row being written.
  always_comb begin
    next_row = '0;
    n        = '0;
    for (int c = 0; c < int'(WIDTH); c++) begin
      n = 4'(ext_a[c]) + 4'(ext_a[c+1]) + 4'(ext_a[c+2]) +
          4'(ext_c[c]) + 4'(ext_c[c+2]) +
          4'(ext_b[c]) + 4'(ext_b[c+1]) + 4'(ext_b[c+2]);
      next_row[c] = (n == 4'd3) || ((n == 4'd2) && ext_c[c+1]);
    end
  end

  // The write data is live during a write and holds the last written row otherwise.
  assign wr_data = wr_en ? next_row : wr_hold;

  // Popcount of the row on the write port.
  always_comb begin
    pop = '0;
    for (int c = 0; c < int'(WIDTH); c++) begin
      pop = pop + CW'(wr_data[c]);
    end
  end

endmodule

// File: doc/life_gen_engine.md
Name: life_gen_engine

Overview:
- Generation engine for the Game of Life grid.
- Streams the current board row by row from a row-wide read port, builds each cell's 3x3 neighbourhood, applies the Life rule, and writes the next-generation rows to a separate write port.
- Sits between the board memory (ping-pong banks, managed externally) and the control/display FSM, which pulses start once per generation.

Parameters:
- WIDTH, 16, cells per row; also the rd_data/wr_data width.
- HEIGHT, 16, rows per board (>= 3).
- AW, 4, row address width; must satisfy 2**AW >= HEIGHT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to compute one generation.
- busy  out  1  high while a generation is in progress.
- done  out  1  one-cycle pulse when the last row has been written.
- rd_en  out  1  row read strobe.
- rd_addr  out  AW  row index to read.
- rd_data  in  WIDTH  row data; valid exactly 1 cycle after rd_en; bit c = column c; 1 = alive.
- wr_en  out  1  row write strobe.
- wr_addr  out  AW  row index being written.
- wr_data  out  WIDTH  next-generation row.
- alive_count  out  AW+$clog2(WIDTH)+1  live cells in the last completed generation.

Behaviour:
- Reset, asynchronous:
  - Outputs: busy=0, done=0, rd_en=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0, alive_count=0.
  - Internal state: FSM to IDLE, row registers to 0.
- FSM states:
  - IDLE: start=1 -> READ, busy=1 from the next cycle. start is ignored in every other state, with no side effects.
  - READ: issues rd_en=1 with rd_addr = 0,1,...,HEIGHT-1 on consecutive cycles, then goes to DRAIN.
  - DRAIN: completes the outstanding computes and writes.
  - FIN: done=1 for one cycle, busy=0 in that same cycle; next state IDLE. alive_count is updated on the FIN edge.
- Timing, with start sampled in cycle 0:
  - rd_en high in cycles 1..HEIGHT.
  - Row r data arrives in cycle r+2.
  - Row r is written in cycle r+3 for r = 0..HEIGHT-1, so the writes are contiguous with no gaps.
  - done is high in cycle HEIGHT+3.
  - Back-to-back: start in the cycle after done is accepted.
- Window:
  - Three row registers: above, centre, below.
  - The row-r write uses row r-1, row r, and the arriving row r+1 (rd_data used combinationally in the write cycle).
  - Row -1 and row HEIGHT are all-zero. Column -1 and column WIDTH are zero, i.e. edge cells are dead-bounded.
- Rule, per cell:
  - n = number of live neighbours among the 8, range 0..8.
  - Next state = 1 iff n==3, or (n==2 and the cell is alive).
  - n >= 4 gives 0, including n = 8.
- alive_count:
  - A running sum of popcount(wr_data) across the generation.
  - The result is published only at FIN, so it holds the previous value while busy.
  - Width covers WIDTH*HEIGHT without overflow.
- Reset mid-generation: everything returns to reset values immediately and no further rd_en/wr_en pulses occur. A partially written board is the caller's problem.
- wr_addr/wr_data are meaningful only when wr_en=1 and hold their last values otherwise. rd_addr is held after READ.

Optional Feature:
- Macro: LIFE_WRAP_EN.
- Defined: the board is a torus. Neighbours across row 0 / row HEIGHT-1 and column 0 / column WIDTH-1 wrap around.
  - The read order becomes HEIGHT-1, 0, 1, ..., HEIGHT-1. The first row read is kept as the "above" of row 0.
  - Row 0 is additionally latched as the "below" of row HEIGHT-1.
  - rd_en is high in cycles 1..HEIGHT+1. Row r is written in cycle r+4. done is in cycle HEIGHT+4.
- Undefined: dead boundary and the timing above. No extra registers or logic.

Test Plan:
- Empty board, start -> HEIGHT writes with wr_data=0 in cycles 3..HEIGHT+2, done in cycle HEIGHT+3, alive_count=0.
- Horizontal blinker at row 5, cols 4-6 -> vertical blinker at col 5, rows 4-6, alive_count=3; a second generation restores the original board.
- 2x2 block at rows 7-8, cols 7-8 -> identical board, alive_count=4. A fully live 3x3 at rows 7-9, cols 7-9 -> only the four corners plus the four edge-centre-adjacent births, and the centre dies (n=8).
- Glider approaching the bottom-right corner, without macro -> cells beyond the edge are dropped and the pattern decays to a 2x2 block. With LIFE_WRAP_EN -> the glider reappears at the top-left; done is in cycle HEIGHT+4.
- start held high for 40 cycles -> exactly one generation runs per IDLE entry. Each done pulse is one cycle. No rd_en/wr_en while IDLE.
- rst asserted in cycle 6 mid-run -> busy, wr_en, rd_en and done all 0 asynchronously; no writes after release; the next start runs a full generation normally.
